// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch controller: one-entry address-tagged fetch buffer in front of a req/ack memory.
// Optional bus-wait timeout is built when FETCH_TIMEOUT_EN is defined.
module inst_fetch_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_ce_i,
    input  logic [31:0] cpu_addr_i,
    input  logic        flush_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq_o,
    output logic        fetch_err_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("inst_fetch_ctrl: TIMEOUT_CYCLES must be in 1..255");
    end

    logic [1:0]  state;
    logic        buf_valid;
    logic [31:0] buf_addr;
    logic [31:0] buf_data;
    logic        hit;
    logic        idle_hit;
    logic        timeout;

    assign hit        = cpu_ce_i && buf_valid && (cpu_addr_i == buf_addr);
    assign idle_hit   = (state == ST_IDLE) && hit;
    assign cpu_data_o = idle_hit ? buf_data : 32'h0;
    assign stallreq_o = cpu_ce_i && !idle_hit;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wait_cnt;
    logic       err_q;

    // Counter restarts whenever a wait phase (REQ or DRAIN) is entered.
    assign timeout = !mem_ack_i && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= 8'h0;
            err_q    <= 1'b0;
        end else begin
            if (state == ST_IDLE || (state == ST_REQ && flush_i))
                wait_cnt <= 8'h0;
            else
                wait_cnt <= wait_cnt + 8'h1;
            err_q <= timeout && ((state == ST_REQ && !flush_i) || state == ST_DRAIN);
        end
    end

    assign fetch_err_o = err_q;
`else
    assign timeout     = 1'b0;
    assign fetch_err_o = 1'b0;
`endif

    // Bus handshake: once mem_req_o rises, mem_req_o/mem_addr_o hold until the
    // cycle mem_ack_i=1 (data valid that same cycle); a request is never withdrawn
    // except by reset or timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            buf_valid  <= 1'b0;
            buf_addr   <= 32'h0;
            buf_data   <= 32'h0;
            mem_req_o  <= 1'b0;
            mem_addr_o <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (flush_i) begin
                        buf_valid <= 1'b0;
                    end else if (cpu_ce_i && !hit) begin
                        mem_addr_o <= cpu_addr_i;
                        mem_req_o  <= 1'b1;
                        state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        state     <= ST_IDLE;
                        if (flush_i) begin
                            buf_valid <= 1'b0;
                        end else begin
                            buf_data  <= mem_data_i;
                            buf_addr  <= mem_addr_o;
                            buf_valid <= 1'b1;
                        end
                    end else if (flush_i) begin
                        buf_valid <= 1'b0;
                        state     <= ST_DRAIN;
                    end else if (timeout) begin
                        // Aborted fetch returns a NOP under its own tag.
                        mem_req_o <= 1'b0;
                        state     <= ST_IDLE;
                        buf_data  <= 32'h0;
                        buf_addr  <= mem_addr_o;
                        buf_valid <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (mem_ack_i || timeout) begin
                        mem_req_o <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    mem_req_o <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Instruction-fetch bus controller between the CPU core's ROM port (`rom_ce_o` / `rom_addr_o` / `rom_data_i`) and a variable-latency instruction memory with a req/ack handshake. It holds a one-entry fetch buffer tagged by address, so a hit returns the instruction with no bus traffic. On a miss it raises a stall request to the pipeline until the word arrives. It sits directly upstream of the core's IF/ID stage and replaces the zero-wait instruction ROM.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum bus wait, in cycles, before a fetch is aborted. Legal range 1..255. Used only with `FETCH_TIMEOUT_EN`.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset. Asserting it clears all state immediately.
- `cpu_ce_i` input 1: fetch enable from the PC stage.
- `cpu_addr_i` input 32: fetch address.
- `flush_i` input 1: pipeline flush; invalidates the buffer.
- `cpu_data_o` output 32: instruction to IF/ID. Combinational from the buffer.
- `stallreq_o` output 1: stall request to the pipeline controller. Combinational.
- `fetch_err_o` output 1: one-cycle pulse when a fetch times out.
- `mem_req_o` output 1: bus request. Registered.
- `mem_addr_o` output 32: bus address. Registered.
- `mem_ack_i` input 1: bus acknowledge; `mem_data_i` is valid in the same cycle.
- `mem_data_i` input 32: bus read data.

## Operation
- Buffer state: `buf_valid`, `buf_addr[31:0]`, `buf_data[31:0]`.
- Hit: `cpu_ce_i=1`, `buf_valid=1` and `cpu_addr_i==buf_addr`.

Outputs by case:
- `cpu_ce_i=0`: `cpu_data_o=0`, `stallreq_o=0`, no request issued.
- Hit in IDLE: `cpu_data_o=buf_data`, `stallreq_o=0`.
- Otherwise, with `cpu_ce_i=1`: `cpu_data_o=0`, `stallreq_o=1`.

FSM states:
- IDLE
  - A miss with `flush_i=0` latches `mem_addr_o<=cpu_addr_i`, sets `mem_req_o<=1` and goes to REQ.
  - `flush_i=1` clears `buf_valid` and stays in IDLE. Flush has priority over starting a request.
- REQ
  - `mem_req_o` and `mem_addr_o` are held stable until `mem_ack_i=1`.
  - On ack with `flush_i=0`: `buf_data<=mem_data_i`, `buf_addr<=mem_addr_o`, `buf_valid<=1`, `mem_req_o<=0`, go to IDLE.
  - `flush_i=1` without ack: clear `buf_valid`, go to DRAIN.
  - `flush_i=1` with ack in the same cycle: discard the data, `buf_valid<=0`, `mem_req_o<=0`, go to IDLE.
- DRAIN
  - An outstanding request cannot be withdrawn, so `mem_req_o` stays 1 until ack.
  - On ack the data is discarded, `mem_req_o<=0`, go to IDLE. `buf_valid` stays 0.
  - `stallreq_o=1` whenever `cpu_ce_i=1`.

Other rules:
- If `cpu_addr_i` changes while in REQ, the current request still completes and is stored under its own tag. The next cycle then misses on the new address.
- Reset (any time, including mid-request): state IDLE, `buf_valid=0`, `buf_addr=0`, `buf_data=0`, `mem_req_o=0`, `mem_addr_o=0`, `fetch_err_o=0`, and the timeout counter cleared. Outputs from reset: `cpu_data_o=0`, `stallreq_o=0`. The memory must tolerate a request that is abandoned by reset.

## Timing
- Miss detected in cycle 0 (`stallreq_o=1`). `mem_req_o=1` from cycle 1.
- Ack in cycle k ≥ 1: buffer updated at the end of cycle k; hit and `stallreq_o=0` in cycle k+1.
- Zero-wait memory (ack in cycle 1) therefore gives 2 stall cycles per miss.
- Back-to-back misses: `mem_req_o` is low for exactly one cycle (IDLE) between requests.
- Hit latency: 0 cycles (combinational).

## Configuration
`FETCH_TIMEOUT_EN` defined:
- An 8-bit wait counter clears on entry to REQ or DRAIN and increments each cycle there without ack.
- When it reaches `TIMEOUT_CYCLES` with no ack: `mem_req_o<=0`, go to IDLE, and pulse `fetch_err_o` for one cycle.
  - From REQ, the buffer is filled with `buf_data<=32'h0` (NOP), `buf_addr<=mem_addr_o`, `buf_valid<=1`.
  - From DRAIN, the buffer is not filled.
- Ack in the timeout cycle: ack wins and no error is flagged.

`FETCH_TIMEOUT_EN` undefined:
- No counter is built; the block waits indefinitely for ack.
- `fetch_err_o` is tied to 0.

## Test plan
- **Reset:** hold `rst=0`, then release. All outputs 0 and `mem_req_o=0`. Assert `rst=0` mid-REQ: `mem_req_o` drops immediately.
- **Miss/hit, zero wait:** `cpu_ce_i=1`, addr `0x00000000`; memory acks in cycle 1 with `0x34011100`. `stallreq_o` is 1 for 2 cycles, then `cpu_data_o=0x34011100`. The same address repeated causes no further `mem_req_o`.
- **Wait states:** ack delayed 5 cycles on addr `0x4`. `mem_addr_o=0x4` is held stable and stall lasts 6 cycles. Next addr `0x8` misses with exactly one idle cycle between the two requests.
- **Flush during REQ:** flush in cycle 2 of a 4-cycle fetch. Enters DRAIN and the ack data is discarded. A refetch of the same address misses again.
- **Flush with simultaneous ack:** data discarded, `buf_valid=0`, back in IDLE the next cycle.
- **Timeout (`FETCH_TIMEOUT_EN`, `TIMEOUT_CYCLES=4`), no ack:** `fetch_err_o` pulses once, `cpu_data_o=0x00000000` and the stall clears. Repeating with ack in the 4th wait cycle gives no error and the real data.
